vram_hud_sequencer: RTL and testbench
=====================================

VRAM_HUD_SEQUENCER -- requirements
Module: vram_hud_sequencer

Interface
REQ-001 SHALL have parameter HUD_BASE0, default 11'd0: VRAM word index of player-0 score field (2 words).
REQ-002 SHALL have parameter HUD_BASE1, default 11'd38: VRAM word index of player-1 score field (2 words).
REQ-003 SHALL have parameter PAL, default 8'h00: low byte of every generated character half-word.
REQ-004 CLK  in  1  single clock, 50 MHz.
REQ-005 RESET  in  1  synchronous, active-high reset.
REQ-006 AVL_CS, AVL_READ, AVL_WRITE  in  1 each  Avalon-MM slave controls.
REQ-007 AVL_ADDR  in  12  Avalon word address; bit 11 = 0 selects VRAM.
REQ-008 AVL_BYTE_EN  in  4  Avalon byte enables.
REQ-009 AVL_WRITEDATA  in  32  Avalon write data.
REQ-010 vs  in  1  VGA vsync, CLK domain.
REQ-011 score0, score1  in  8 each  unsigned scores 0-255.
REQ-012 inv  in  2  per-player inverse-glyph bit.
REQ-013 ram_addr  out  11  VRAM port-A address.
REQ-014 ram_byteen  out  4  port-A byte enables.
REQ-015 ram_wdata  out  32  port-A write data.
REQ-016 ram_wren, ram_rden  out  1 each  port-A write/read enables.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 frame_done  out  1  one-cycle pulse when a HUD update completes.

Function
REQ-019 avl_vram = AVL_CS & ~AVL_ADDR[11] & (AVL_READ | AVL_WRITE); Avalon SHALL have absolute priority on port A.
REQ-020 When avl_vram: ram_addr=AVL_ADDR[10:0], ram_byteen=AVL_BYTE_EN, ram_wdata=AVL_WRITEDATA, ram_wren=AVL_WRITE, ram_rden=AVL_READ, combinationally, zero added latency.
REQ-021 Otherwise: ram_rden=0, ram_byteen=4'hF, ram_wren=1 only in WR_LO/WR_HI, address/data from the sequencer.
REQ-022 vs rising edge detected via register vs_q (vs & ~vs_q).
REQ-023 States: IDLE, LOAD, CONV, WR_LO, WR_HI, NEXT.
REQ-024 IDLE -> LOAD on edge or pending=1; pending cleared on that transition.
REQ-025 LOAD: p=0; snap0<=score0, snap1<=score1, inv_s<=inv; -> CONV next cycle.
REQ-026 LOAD: if snap_p equals last_p and force=0, skip to NEXT; else rem<=snap_p, h=t=o=0, -> CONV.
REQ-027 CONV, one step/cycle: rem>=100: rem-=100, h++; else rem>=10: rem-=10, t++; else o=rem, -> WR_LO. Max 8 cycles (255), min 1 (0).
REQ-028 Char half = {inv_s[p], 7'h30+digit, PAL}; space half = {1'b0, 7'h20, PAL}.
REQ-029 WR_LO writes word BASE_p = {tens half, hundreds half}; WR_HI writes BASE_p+1 = {space half, ones half}.
REQ-030 In WR_LO/WR_HI, if avl_vram, hold state and data (stall); advance only on a cycle the write issues.
REQ-031 After WR_HI: last_p<=snap_p -> NEXT.
REQ-032 NEXT: p=0 -> p=1, evaluate REQ-026 for player 1; p=1 -> IDLE, force<=0, frame_done=1 for one cycle.
REQ-033 Vs edge while busy sets pending (one deep; extra edges merge); no restart mid-update.
REQ-034 Score inputs changing after LOAD SHALL NOT affect the update in progress.
REQ-035 Avalon accesses with AVL_ADDR[11]=1 SHALL NOT stall the sequencer.

Reset
REQ-036 RESET: state=IDLE, vs_q=0, pending=0, force=1, p=0, last0=last1=0, busy=0, frame_done=0; any in-progress write abandoned, no further HUD writes.
REQ-037 During reset, port-A outputs still follow REQ-020/021 with ram_wren from sequencer = 0.

Verification
REQ-038 After reset, score0=123, score1=7, inv=0, vs pulse -> writes: [0]=32'h3200_3100, [1]=32'h2000_3300, [38]=32'h3000_3000, [39]=32'h2000_3700; then frame_done pulse.
REQ-039 Second vs pulse, scores unchanged -> zero ram_wren cycles, frame_done still pulses.
REQ-040 Continuous Avalon VRAM writes over 10 cycles during WR_LO -> port A shows only Avalon traffic; HUD write issues first free cycle, data unchanged.
REQ-041 score0=255, inv=2'b01 -> CONV exactly 8 cycles; [0]=32'hB500_B200, [1]=32'h2000_B500.
REQ-042 Two vs edges during update -> exactly one extra update follows, none more.
REQ-043 RESET asserted in CONV -> no HUD write occurs; next vs rewrites both fields (force=1).

Source files
------------

// File: rtl/vram_hud_sequencer.sv
// vram_hud_sequencer: writes two 3-digit score fields into VRAM port A.
// Avalon VRAM traffic always owns port A; the sequencer stalls behind it.
// Ports:
//   CLK, RESET           clock, sync active-high reset
//   AVL_CS/READ/WRITE    Avalon-MM slave controls
//   AVL_ADDR[11:0]       word address, bit 11 = 0 selects VRAM
//   AVL_BYTE_EN[3:0]     byte enables
//   AVL_WRITEDATA[31:0]  write data
//   vs                   vsync, starts an update on its rising edge
//   score0/score1[7:0]   player scores
//   inv[1:0]             per-player inverse-glyph bit
//   ram_*                VRAM port-A address/byteen/data/wren/rden
//   busy                 sequencer not idle
//   frame_done           one-cycle pulse at end of an update
module vram_hud_sequencer #(
  parameter logic [10:0] HUD_BASE0 = 11'd0,
  parameter logic [10:0] HUD_BASE1 = 11'd38,
  parameter logic [7:0]  PAL       = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        AVL_CS,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic [11:0] AVL_ADDR,
  input  logic [3:0]  AVL_BYTE_EN,
  input  logic [31:0] AVL_WRITEDATA,
  input  logic        vs,
  input  logic [7:0]  score0,
  input  logic [7:0]  score1,
  input  logic [1:0]  inv,
  output logic [10:0] ram_addr,
  output logic [3:0]  ram_byteen,
  output logic [31:0] ram_wdata,
  output logic        ram_wren,
  output logic        ram_rden,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    IDLE, LOAD, CONV, WR_LO, WR_HI, NEXT
  } state_t;

  state_t state, state_n;

  logic       vs_q, pending, force_q, p;
  logic [7:0] snap0, snap1, last0, last1, rem;
  logic [3:0] h, t, o;
  logic [1:0] inv_s;

  logic        avl_vram, vs_edge, skip, seq_wr, iv_p;
  logic [7:0]  cur, lst;
  logic [10:0] base;
  logic [31:0] seq_lo, seq_hi;

  function automatic logic [15:0] chr(
    input logic       iv,
    input logic [3:0] d
  );
    return {iv, 7'h30 + {3'b000, d}, PAL};
  endfunction

  assign avl_vram = AVL_CS & ~AVL_ADDR[11]
                  & (AVL_READ | AVL_WRITE);
  assign vs_edge  = vs & ~vs_q;
  assign busy     = (state != IDLE);

  // LOAD compares player 0 against the value being
  // snapped this cycle; NEXT compares player 1's snapshot.
  assign cur  = (state == LOAD) ? score0 : snap1;
  assign lst  = (state == LOAD) ? last0 : last1;
  assign skip = (cur == lst) && !force_q;

  assign iv_p   = inv_s[p];
  assign base   = p ? HUD_BASE1 : HUD_BASE0;
  assign seq_lo = {chr(iv_p, t), chr(iv_p, h)};
  assign seq_hi = {1'b0, 7'h20, PAL, chr(iv_p, o)};
  assign seq_wr = ((state == WR_LO) || (state == WR_HI))
                && !RESET;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (vs_edge || pending) state_n = LOAD;
      LOAD:  state_n = skip ? NEXT : CONV;
      CONV:  if (rem < 8'd10) state_n = WR_LO;
      WR_LO: if (!avl_vram) state_n = WR_HI;
      WR_HI: if (!avl_vram) state_n = NEXT;
      NEXT: begin
        if (p) state_n = IDLE;
        else   state_n = skip ? NEXT : CONV;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ram_addr   = (state == WR_HI) ? base + 11'd1 : base;
    ram_byteen = 4'hF;
    ram_wdata  = (state == WR_HI) ? seq_hi : seq_lo;
    ram_wren   = seq_wr;
    ram_rden   = 1'b0;
    if (avl_vram) begin
      ram_addr   = AVL_ADDR[10:0];
      ram_byteen = AVL_BYTE_EN;
      ram_wdata  = AVL_WRITEDATA;
      ram_wren   = AVL_WRITE;
      ram_rden   = AVL_READ;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      vs_q       <= 1'b0;
      pending    <= 1'b0;
      force_q    <= 1'b1;
      p          <= 1'b0;
      last0      <= 8'd0;
      last1      <= 8'd0;
      snap0      <= 8'd0;
      snap1      <= 8'd0;
      inv_s      <= 2'b00;
      rem        <= 8'd0;
      h          <= 4'd0;
      t          <= 4'd0;
      o          <= 4'd0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      vs_q       <= vs;
      frame_done <= (state == NEXT) && p;
      if (state == IDLE)  pending <= 1'b0;
      else if (vs_edge)   pending <= 1'b1;
      unique case (state)
        LOAD: begin
          p     <= 1'b0;
          snap0 <= score0;
          snap1 <= score1;
          inv_s <= inv;
          if (!skip) begin
            rem <= score0;
            h   <= 4'd0;
            t   <= 4'd0;
            o   <= 4'd0;
          end
        end
        CONV: begin
          if (rem >= 8'd100) begin
            rem <= rem - 8'd100;
            h   <= h + 4'd1;
          end else if (rem >= 8'd10) begin
            rem <= rem - 8'd10;
            t   <= t + 4'd1;
          end else begin
            o   <= rem[3:0];
          end
        end
        WR_HI: begin
          if (!avl_vram) begin
            if (p) last1 <= snap1;
            else   last0 <= snap0;
          end
        end
        NEXT: begin
          if (!p) begin
            p <= 1'b1;
            if (!skip) begin
              rem <= snap1;
              h   <= 4'd0;
              t   <= 4'd0;
              o   <= 4'd0;
            end
          end else begin
            force_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_hud_sequencer.sv
// tb_vram_hud_sequencer: directed bench with a score-to-VRAM model.
// Expected HUD writes are queued by the model and popped per write.
module tb_vram_hud_sequencer;

  localparam int B0 = 0;
  localparam int B1 = 38;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        AVL_CS = 1'b0;
  logic        AVL_READ = 1'b0;
  logic        AVL_WRITE = 1'b0;
  logic [11:0] AVL_ADDR = '0;
  logic [3:0]  AVL_BYTE_EN = '0;
  logic [31:0] AVL_WRITEDATA = '0;
  logic        vs = 1'b0;
  logic [7:0]  score0 = '0;
  logic [7:0]  score1 = '0;
  logic [1:0]  inv = '0;
  logic [10:0] ram_addr;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic        ram_wren, ram_rden, busy, frame_done;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int fd_count = 0, wr_count = 0, t_busy = 0, t_first = 0;
  bit busy_q = 0, fd_q = 0, first_pend = 0;
  logic [31:0] vram [0:2047];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  int m_last[2];
  bit m_force;

  always #5 CLK = ~CLK;

  vram_hud_sequencer dut (
    .CLK(CLK), .RESET(RESET),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ),
    .AVL_WRITE(AVL_WRITE), .AVL_ADDR(AVL_ADDR),
    .AVL_BYTE_EN(AVL_BYTE_EN),
    .AVL_WRITEDATA(AVL_WRITEDATA),
    .vs(vs), .score0(score0), .score1(score1),
    .inv(inv), .ram_addr(ram_addr),
    .ram_byteen(ram_byteen), .ram_wdata(ram_wdata),
    .ram_wren(ram_wren), .ram_rden(ram_rden),
    .busy(busy), .frame_done(frame_done)
  );

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [15:0] ch(input bit iv,
                                     input int d);
    logic [7:0] c;
    c = 8'(8'h30 + d);
    return {iv, c[6:0], 8'h00};
  endfunction

  function automatic logic [31:0] w_lo(input int s,
                                       input bit iv);
    return {ch(iv, (s / 10) % 10), ch(iv, s / 100)};
  endfunction

  function automatic logic [31:0] w_hi(input int s,
                                       input bit iv);
    return {16'h2000, ch(iv, s % 10)};
  endfunction

  function automatic int conv(input int s);
    return s / 100 + (s % 100) / 10 + 1;
  endfunction

  task automatic model_frame(input int s0, input int s1,
                             input logic [1:0] iv);
    int s, b;
    for (int p = 0; p < 2; p++) begin
      s = p ? s1 : s0;
      b = p ? B1 : B0;
      if (m_force || s != m_last[p]) begin
        exp_addr.push_back(b);
        exp_data.push_back(w_lo(s, iv[p]));
        exp_addr.push_back(b + 1);
        exp_data.push_back(w_hi(s, iv[p]));
      end
      m_last[p] = s;
    end
    m_force = 0;
  endtask

  always @(negedge CLK) begin : mon
    bit avl;
    cyc++;
    avl = AVL_CS & ~AVL_ADDR[11] & (AVL_READ | AVL_WRITE);
    if (avl) begin
      chk(ram_addr == AVL_ADDR[10:0]
          && ram_byteen == AVL_BYTE_EN
          && ram_wdata == AVL_WRITEDATA
          && ram_wren == AVL_WRITE
          && ram_rden == AVL_READ, "avl_pass",
          64'({ram_addr, ram_wren, ram_rden}),
          64'({AVL_ADDR[10:0], AVL_WRITE, AVL_READ}));
      if (AVL_WRITE) vram[AVL_ADDR[10:0]] = AVL_WRITEDATA;
    end else begin
      chk(!ram_rden && ram_byteen == 4'hF, "seq_ctl",
          64'({ram_rden, ram_byteen}), 64'({1'b0, 4'hF}));
      if (ram_wren) begin
        wr_count++;
        chk(!RESET, "wr_in_reset", 64'(RESET), 64'd0);
        if (first_pend) begin
          t_first = cyc;
          first_pend = 0;
        end
        chk(exp_addr.size() != 0, "unexpected_write",
            64'(ram_addr), 64'd0);
        if (exp_addr.size() != 0) begin
          chk(ram_addr == 11'(exp_addr[0]), "hud_addr",
              64'(ram_addr), 64'(exp_addr[0]));
          chk(ram_wdata == exp_data[0], "hud_data",
              64'(ram_wdata), 64'(exp_data[0]));
          void'(exp_addr.pop_front());
          void'(exp_data.pop_front());
        end
        vram[ram_addr] = ram_wdata;
      end
    end
    if (busy && !busy_q) begin
      t_busy = cyc;
      first_pend = 1;
    end
    busy_q = busy;
    if (frame_done) begin
      fd_count++;
      chk(!fd_q, "fd_one_cycle", 64'(fd_q), 64'd0);
    end
    fd_q = frame_done;
  end

  task automatic pulse_vs();
    @(posedge CLK); #1 vs = 1'b1;
    @(posedge CLK); #1 vs = 1'b0;
  endtask

  task automatic wait_fd(input int target);
    for (int i = 0; i < 300 && fd_count < target; i++)
      @(posedge CLK);
    chk(fd_count >= target, "fd_timeout",
        64'(fd_count), 64'(target));
    #1;
  endtask

  task automatic wait_busy();
    bit seen;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      seen = busy;
    end
    chk(seen, "busy_timeout", 64'(seen), 64'd1);
    @(posedge CLK); #1;
  endtask

  initial begin
    int w0;
    m_last[0] = 0; m_last[1] = 0; m_force = 1;
    // reset with an Avalon read passing through
    AVL_CS = 1; AVL_READ = 1;
    AVL_ADDR = 12'h005; AVL_BYTE_EN = 4'h3;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(frame_done == 1'b0, "rst_fd", 64'(frame_done), 64'd0);
    @(posedge CLK); #1;
    RESET = 0; AVL_CS = 0; AVL_READ = 0;

    // first update, forced write of both fields
    score0 = 8'd123; score1 = 8'd7; inv = 2'b00;
    model_frame(123, 7, 2'b00);
    pulse_vs();
    wait_fd(1);
    chk(vram[0] == 32'h3200_3100, "v0", 64'(vram[0]), 64'h32003100);
    chk(vram[1] == 32'h2000_3300, "v1", 64'(vram[1]), 64'h20003300);
    chk(vram[38] == 32'h3000_3000, "v38", 64'(vram[38]), 64'h30003000);
    chk(vram[39] == 32'h2000_3700, "v39", 64'(vram[39]), 64'h20003700);
    chk(t_first - t_busy == 1 + conv(123), "lat123",
        64'(t_first - t_busy), 64'(1 + conv(123)));

    // unchanged scores: no writes, still a frame_done
    w0 = wr_count;
    pulse_vs();
    wait_fd(2);
    chk(wr_count == w0, "no_writes", 64'(wr_count), 64'(w0));

    // Avalon stall during WR_LO
    score0 = 8'd45;
    model_frame(45, 7, 2'b00);
    pulse_vs();
    wait_busy();
    AVL_CS = 1; AVL_WRITE = 1; AVL_BYTE_EN = 4'hF;
    for (int i = 0; i < 16; i++) begin
      AVL_ADDR = 12'(12'h100 + i);
      AVL_WRITEDATA = 32'hA5A5_0000 + 32'(i);
      @(posedge CLK); #1;
    end
    AVL_CS = 0; AVL_WRITE = 0;
    @(negedge CLK);
    chk(ram_wren && ram_addr == 11'd0
        && ram_wdata == 32'h3400_3000, "first_free",
        64'({ram_wren, ram_addr, ram_wdata}),
        64'({1'b1, 11'd0, 32'h34003000}));
    wait_fd(3);
    chk(vram[16'h10F] == 32'hA5A5_000F, "avl_data",
        64'(vram[16'h10F]), 64'hA5A5000F);

    // 255 with inverse glyph, non-VRAM Avalon traffic
    score0 = 8'd255; inv = 2'b01;
    AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 12'h800;
    model_frame(255, 7, 2'b01);
    pulse_vs();
    wait_fd(4);
    AVL_CS = 0; AVL_WRITE = 0; AVL_ADDR = 12'h000;
    chk(t_first - t_busy == 9, "lat255",
        64'(t_first - t_busy), 64'd9);
    chk(t_first - t_busy == 1 + conv(255), "lat255m",
        64'(t_first - t_busy), 64'(1 + conv(255)));
    chk(vram[0] == 32'hB500_B200, "inv0", 64'(vram[0]), 64'hB500B200);
    chk(vram[1] == 32'h2000_B500, "inv1", 64'(vram[1]), 64'h2000B500);

    // two vs edges mid-update, scores change after LOAD
    score0 = 8'd10; score1 = 8'd200; inv = 2'b00;
    model_frame(10, 200, 2'b00);
    pulse_vs();
    wait_busy();
    score0 = 8'd99; score1 = 8'd0;
    model_frame(99, 0, 2'b00);
    pulse_vs();
    pulse_vs();
    wait_fd(6);
    repeat (30) @(posedge CLK);
    chk(fd_count == 6, "one_extra", 64'(fd_count), 64'd6);
    chk(vram[38] == 32'h3000_3000, "p1_zero",
        64'(vram[38]), 64'h30003000);

    // reset during CONV abandons the update
    score0 = 8'd255;
    pulse_vs();
    wait_busy();
    w0 = wr_count;
    @(posedge CLK); #1 RESET = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk(busy == 1'b0, "rst_mid", 64'(busy), 64'd0);
    @(posedge CLK); #1 RESET = 0;
    m_last[0] = 0; m_last[1] = 0; m_force = 1;
    repeat (20) @(posedge CLK);
    chk(wr_count == w0, "abandon", 64'(wr_count), 64'(w0));
    chk(fd_count == 6, "no_fd_abort", 64'(fd_count), 64'd6);
    #1;
    model_frame(255, 0, 2'b00);
    pulse_vs();
    wait_fd(7);
    chk(wr_count == w0 + 4, "forced_rewrite",
        64'(wr_count), 64'(w0 + 4));
    chk(vram[39] == 32'h2000_3000, "v39_zero",
        64'(vram[39]), 64'h20003000);

    chk(exp_addr.size() == 0, "queue_drained",
        64'(exp_addr.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
